run_expander: RTL and testbench
===============================

RUN_EXPANDER -- requirements
Module: run_expander

Interface
REQ-001 Parameter DATA_W, default 128, meaning width of the repeated data word.
REQ-002 Parameter CNT_W, default 32, meaning width of the repeat count; legal range 2..32.
REQ-003 Port clk, input, 1 bit: single clock, rising edge active.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: a run descriptor is present.
REQ-006 Port in_ready, output, 1 bit: the block accepts the descriptor this cycle.
REQ-007 Port in_data, input, DATA_W bits: the word to repeat.
REQ-008 Port in_count, input, CNT_W bits: the number of repeats, unsigned.
REQ-009 Port out_valid, output, 1 bit: out_data is valid.
REQ-010 Port out_ready, input, 1 bit: the downstream consumes the beat.
REQ-011 Port out_data, output, DATA_W bits: the repeated word.
REQ-012 Port out_last, output, 1 bit: final beat of the current run.
REQ-013 Port flush, input, 1 bit: synchronous abort of the active run.
REQ-014 Port run_cnt, output, CNT_W bits: completed-run counter.
REQ-015 Port drop_cnt, output, CNT_W bits: zero-count descriptor counter.

Function
REQ-016 The block shall hold one active run in registers: act_valid, act_data (DATA_W bits) and act_rem (CNT_W bits).
REQ-017 A descriptor transfer shall occur when in_valid=1 and in_ready=1; a beat transfer shall occur when out_valid=1 and out_ready=1.
REQ-018 in_ready shall be combinational and equal to !flush && (!act_valid || (beat transfer && act_rem==1)), giving zero-bubble back-to-back runs.
REQ-019 out_valid shall equal act_valid, out_data shall equal act_data, and out_last shall equal act_valid && act_rem==1; all three shall be driven from registers with no combinational path from inputs.
REQ-020 On a descriptor transfer with in_count>=1, the block shall set act_valid=1, act_data=in_data and act_rem=in_count on the next edge; the first beat shall be visible 1 cycle after acceptance.
REQ-021 On a descriptor transfer with in_count==0, the block shall produce no beat, shall leave the active state unchanged, and shall increment drop_cnt.
REQ-022 On a beat transfer with act_rem>1, the block shall decrement act_rem by 1 and hold act_data.
REQ-023 On a beat transfer with act_rem==1 and no new nonzero descriptor accepted in the same cycle, the block shall clear act_valid.
REQ-024 On a beat transfer with act_rem==1 and a new nonzero descriptor accepted in the same cycle, the block shall load the new run with act_valid held at 1.
REQ-025 The block shall increment run_cnt on every beat transfer with out_last=1.
REQ-026 When out_ready=0, act_rem, act_data and out_valid shall hold.
REQ-027 When flush=1, the block shall clear act_valid on the next edge, shall hold in_ready at 0, and shall not increment run_cnt; flush shall take priority over a simultaneous beat transfer.
REQ-028 run_cnt and drop_cnt shall wrap modulo 2^CNT_W.
REQ-029 An in_count of all-ones shall emit exactly 2^CNT_W-1 beats, with no decrement underflow.

Reset
REQ-030 While rst_n=0, independent of clk, the block shall hold act_valid=0, act_rem=0, act_data=0, run_cnt=0 and drop_cnt=0, so that out_valid=0, out_last=0 and out_data=0.
REQ-031 A reset asserted mid-run shall discard the run without asserting out_last.
REQ-032 The first descriptor transfer shall be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 The bench shall cover: in_data=A, in_count=3, out_ready held at 1 -> 3 beats of A, out_last on the 3rd beat only, run_cnt=1.
REQ-034 The bench shall cover: runs (A,2) and (B,1) presented back-to-back with out_ready=1 -> beat sequence A,A,B on consecutive cycles with no bubble, and in_ready=1 on the last A beat.
REQ-035 The bench shall cover: descriptor (C,0) followed by (D,1) -> no C beat appears, drop_cnt=1, and a single D beat is produced with out_last=1.
REQ-036 The bench shall cover: run (E,4) with out_ready toggling 1,0,0,1,1,1 -> exactly 4 E beats, with out_data and act_rem stable during the stalls.
REQ-037 The bench shall cover: run (F,5) with flush asserted after 2 beats -> out_valid=0 on the next cycle, run_cnt unchanged, and the next descriptor accepted normally.
REQ-038 The bench shall cover: rst_n pulsed low mid-run (G,10) between clock edges -> out_valid drops immediately, and all counters read 0.

Source files
------------

// File: rtl/run_expander.sv
// Run-length expander: accepts {data, count} descriptors and replays the data
// word count times on a valid/ready output stream. Back-to-back runs are
// seamless; zero-count descriptors are absorbed and counted; flush aborts the
// active run.
module run_expander #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              flush,
  output logic [CNT_W-1:0]  run_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic              act_valid, act_valid_d;
  logic [DATA_W-1:0] act_data, act_data_d;
  logic [CNT_W-1:0]  act_rem, act_rem_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic rem_is_one;
  logic beat;
  logic desc;
  logic count_nz;

  assign rem_is_one = (act_rem == CNT_W'(1));
  assign beat       = act_valid && out_ready;
  assign count_nz   = (in_count != '0);
  // Accept a new run while idle, or in the same cycle the last beat leaves.
  assign in_ready   = !flush && (!act_valid || (beat && rem_is_one));
  assign desc       = in_valid && in_ready;

  // Outputs come straight from state registers.
  assign out_valid = act_valid;
  assign out_data  = act_data;
  assign out_last  = act_valid && rem_is_one;
  assign run_cnt   = run_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  // Next-state for the active run and the statistics counters.
  always_comb begin
    act_valid_d = act_valid;
    act_data_d  = act_data;
    act_rem_d   = act_rem;
    run_cnt_d   = run_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (flush) begin
      // Flush wins over any beat in the same cycle; in_ready is already low.
      act_valid_d = 1'b0;
      act_rem_d   = '0;
    end else begin
      if (beat) begin
        // Last beat leaves act_rem at zero, so all-ones counts never underflow.
        act_rem_d = act_rem - CNT_W'(1);
        if (rem_is_one) begin
          act_valid_d = 1'b0;
          run_cnt_d   = run_cnt_q + CNT_W'(1);
        end
      end
      if (desc) begin
        if (count_nz) begin
          act_valid_d = 1'b1;
          act_data_d  = in_data;
          act_rem_d   = in_count;
        end else begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_valid  <= 1'b0;
      act_data   <= '0;
      act_rem    <= '0;
      run_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      act_valid  <= act_valid_d;
      act_data   <= act_data_d;
      act_rem    <= act_rem_d;
      run_cnt_q  <= run_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_run_expander.sv
// Directed bench for run_expander: a per-cycle vector table for the main
// scenarios, plus hand sequences for all-ones count, counter wrap and reset.
module tb_run_expander;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int NV = 30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          flush;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  run_expander #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .flush(flush), .run_cnt(run_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;
    logic          ordy;
    logic          fl;
    logic          ir;
    logic          ov;
    logic [DW-1:0] od;
    logic          ol;
    logic [CW-1:0] rc;
    logic [CW-1:0] dc;
    logic [CW-1:0] rem;
    logic          chk_rem;
  } vec_t;

  vec_t vt[NV];

  function automatic vec_t mk(logic iv, logic [DW-1:0] id, logic [CW-1:0] ic, logic ordy,
                              logic fl, logic ir, logic ov, logic [DW-1:0] od, logic ol,
                              logic [CW-1:0] rc, logic [CW-1:0] dc, logic [CW-1:0] rem,
                              logic chk_rem);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy; v.fl = fl;
    v.ir = ir; v.ov = ov; v.od = od; v.ol = ol; v.rc = rc; v.dc = dc;
    v.rem = rem; v.chk_rem = chk_rem;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  localparam logic [DW-1:0] A = 16'hA0A0, X = 16'h1111, Y = 16'h2222, C = 16'hCCCC;
  localparam logic [DW-1:0] D = 16'hDDDD, E = 16'hEEEE, F = 16'hF0F0, H = 16'h1234;
  localparam logic [DW-1:0] G = 16'h6666;

  int beats;
  int last_at;

  initial begin
    // Expectations are the outputs seen just before the edge the inputs hit.
    //           iv id ic  or fl | ir ov od ol rc dc rem chk
    vt[0]  = mk(1, A, 3, 1, 0,   1, 0, 0, 0, 0, 0, 0, 1);
    vt[1]  = mk(0, 0, 0, 1, 0,   0, 1, A, 0, 0, 0, 3, 1);
    vt[2]  = mk(0, 0, 0, 1, 0,   0, 1, A, 0, 0, 0, 2, 1);
    vt[3]  = mk(0, 0, 0, 1, 0,   1, 1, A, 1, 0, 0, 1, 1);
    vt[4]  = mk(0, 0, 0, 1, 0,   1, 0, A, 0, 1, 0, 0, 1);
    // back-to-back (X,2),(Y,1)
    vt[5]  = mk(1, X, 2, 1, 0,   1, 0, A, 0, 1, 0, 0, 1);
    vt[6]  = mk(1, Y, 1, 1, 0,   0, 1, X, 0, 1, 0, 2, 1);
    vt[7]  = mk(1, Y, 1, 1, 0,   1, 1, X, 1, 1, 0, 1, 1);
    vt[8]  = mk(0, 0, 0, 1, 0,   1, 1, Y, 1, 2, 0, 1, 1);
    vt[9]  = mk(0, 0, 0, 1, 0,   1, 0, Y, 0, 3, 0, 0, 1);
    // zero-count drop then (D,1)
    vt[10] = mk(1, C, 0, 1, 0,   1, 0, Y, 0, 3, 0, 0, 1);
    vt[11] = mk(1, D, 1, 1, 0,   1, 0, Y, 0, 3, 1, 0, 1);
    vt[12] = mk(0, 0, 0, 1, 0,   1, 1, D, 1, 3, 1, 1, 1);
    vt[13] = mk(0, 0, 0, 1, 0,   1, 0, D, 0, 4, 1, 0, 1);
    // (E,4) with out_ready 1,0,0,1,1,1
    vt[14] = mk(1, E, 4, 1, 0,   1, 0, D, 0, 4, 1, 0, 1);
    vt[15] = mk(0, 0, 0, 1, 0,   0, 1, E, 0, 4, 1, 4, 1);
    vt[16] = mk(0, 0, 0, 0, 0,   0, 1, E, 0, 4, 1, 3, 1);
    vt[17] = mk(0, 0, 0, 0, 0,   0, 1, E, 0, 4, 1, 3, 1);
    vt[18] = mk(0, 0, 0, 1, 0,   0, 1, E, 0, 4, 1, 3, 1);
    vt[19] = mk(0, 0, 0, 1, 0,   0, 1, E, 0, 4, 1, 2, 1);
    vt[20] = mk(0, 0, 0, 1, 0,   1, 1, E, 1, 4, 1, 1, 1);
    vt[21] = mk(0, 0, 0, 1, 0,   1, 0, E, 0, 5, 1, 0, 1);
    // (F,5) flushed after two beats, then (H,2)
    vt[22] = mk(1, F, 5, 1, 0,   1, 0, E, 0, 5, 1, 0, 1);
    vt[23] = mk(0, 0, 0, 1, 0,   0, 1, F, 0, 5, 1, 5, 1);
    vt[24] = mk(0, 0, 0, 1, 0,   0, 1, F, 0, 5, 1, 4, 1);
    vt[25] = mk(1, H, 2, 1, 1,   0, 1, F, 0, 5, 1, 3, 1);
    vt[26] = mk(1, H, 2, 1, 0,   1, 0, F, 0, 5, 1, 0, 0);
    vt[27] = mk(0, 0, 0, 1, 0,   0, 1, H, 0, 5, 1, 2, 1);
    vt[28] = mk(0, 0, 0, 1, 0,   1, 1, H, 1, 5, 1, 1, 1);
    vt[29] = mk(0, 0, 0, 1, 0,   1, 0, H, 0, 6, 1, 0, 1);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0;
    out_ready = 1'b0; flush = 1'b0;
    #1;
    chk("rst_out_valid", 0, 32'(out_valid), 0);
    chk("rst_out_last", 0, 32'(out_last), 0);
    chk("rst_out_data", 0, 32'(out_data), 0);
    chk("rst_run_cnt", 0, 32'(run_cnt), 0);
    chk("rst_drop_cnt", 0, 32'(drop_cnt), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = vt[i].iv; in_data = vt[i].id; in_count = vt[i].ic;
      out_ready = vt[i].ordy; flush = vt[i].fl;
      #1;
      chk("in_ready", i, 32'(in_ready), 32'(vt[i].ir));
      chk("out_valid", i, 32'(out_valid), 32'(vt[i].ov));
      chk("out_data", i, 32'(out_data), 32'(vt[i].od));
      chk("out_last", i, 32'(out_last), 32'(vt[i].ol));
      chk("run_cnt", i, 32'(run_cnt), 32'(vt[i].rc));
      chk("drop_cnt", i, 32'(drop_cnt), 32'(vt[i].dc));
      if (vt[i].chk_rem) chk("act_rem", i, 32'(dut.act_rem), 32'(vt[i].rem));
    end

    // All-ones count: exactly 15 beats, last flagged on beat 15.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h5555; in_count = 4'hF; out_ready = 1'b1; flush = 1'b0;
    beats = 0; last_at = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        beats++;
        if (out_last && last_at == 0) last_at = beats;
      end
    end
    chk("ones_beats", 0, 32'(beats), 15);
    chk("ones_last_at", 0, 32'(last_at), 15);
    chk("ones_run_cnt", 0, 32'(run_cnt), 7);

    // Nine back-to-back single-beat runs push run_cnt from 7 through 16 -> wraps to 0.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = DW'(k); in_count = 4'd1;
      #1;
      chk("wrap_in_ready", k, 32'(in_ready), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("wrap_run_cnt", 0, 32'(run_cnt), 0);
    chk("wrap_out_valid", 0, 32'(out_valid), 0);

    // Reset pulsed between edges in the middle of (G,10).
    @(negedge clk);
    in_valid = 1'b1; in_data = G; in_count = 4'd10;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("g_mid_valid", 0, 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("g_rst_out_valid", 0, 32'(out_valid), 0);
    chk("g_rst_out_last", 0, 32'(out_last), 0);
    chk("g_rst_out_data", 0, 32'(out_data), 0);
    chk("g_rst_run_cnt", 0, 32'(run_cnt), 0);
    chk("g_rst_drop_cnt", 0, 32'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = H; in_count = 4'd1;
    #1;
    chk("post_rst_in_ready", 0, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_rst_out_valid", 0, 32'(out_valid), 1);
    chk("post_rst_out_data", 0, 32'(out_data), 32'(H));
    chk("post_rst_out_last", 0, 32'(out_last), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
